// File: rtl/time_set_ctrl.sv
// Set-mode sequencer for the digital clock: debounced MODE/INC keys,
// increment strobes with auto-repeat, set-state timeout and field blink.
module time_set_ctrl #(
    parameter int DEB_CYCLES   = 1000000,
    parameter int REPEAT_START = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int TIMEOUT_S    = 10
) (
    input  logic       CP50,
    input  logic       nCR,
    input  logic       Tick1Hz,
    input  logic       KeyMode,
    input  logic       KeyInc,
    output logic       IncH,
    output logic       IncM,
    output logic       IncAH,
    output logic       IncAM,
    output logic       HoldRun,
    output logic       ClrSec,
    output logic       DisplayA,
    output logic       FieldBlank,
    output logic [2:0] Field
);

    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int RCW = $clog2(REPEAT_START + 1);
    localparam int TCW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } state_t;

    // key index 0 = MODE, 1 = INC
    logic [1:0]     raw;
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     lvl;
    logic [1:0]     prs;
    logic [DCW-1:0] dcnt [2];

    state_t         state;
    state_t         nxt;
    logic [TCW-1:0] tcnt;
    logic [TCW-1:0] tcnt_n;
    logic           timeout;
    logic           armed;
    logic           armed_n;
    logic [RCW-1:0] rcnt;
    logic [RCW-1:0] rcnt_n;
    logic           phase;
    logic           phase_n;
    logic           press_ok;
    logic           rep_fire;
    logic           fire;
    logic           mode_p;
    logic           inc_p;
    logic           inc_lvl;

    assign raw     = {KeyInc, KeyMode};
    assign mode_p  = prs[0];
    assign inc_p   = prs[1];
    assign inc_lvl = lvl[1];
    assign Field   = state;

    // Synchronise and debounce both keys; emit one-cycle press events.
    always_ff @(posedge CP50) begin
        if (!nCR) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            prs   <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prs   <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == lvl[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DCW'(DEB_CYCLES - 1)) begin
                    dcnt[i] <= '0;
                    lvl[i]  <= sync2[i];
                    prs[i]  <= sync2[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Next state, timeout, repeat timing and blink phase.
    always_comb begin
        tcnt_n   = tcnt;
        nxt      = state;
        timeout  = 1'b0;
        armed_n  = armed;
        rcnt_n   = rcnt;
        phase_n  = phase;
        press_ok = 1'b0;
        rep_fire = 1'b0;
        fire     = 1'b0;

        if (state == RUN || mode_p || inc_p)
            tcnt_n = '0;
        else if (Tick1Hz && tcnt != TCW'(TIMEOUT_S))
            tcnt_n = tcnt + 1'b1;
        timeout = (state != RUN) && (tcnt_n == TCW'(TIMEOUT_S));

        if (mode_p) begin
            unique case (state)
                RUN:     nxt = SET_H;
                SET_H:   nxt = SET_M;
                SET_M:   nxt = SET_AH;
                SET_AH:  nxt = SET_AM;
                SET_AM:  nxt = RUN;
                default: nxt = RUN;
            endcase
        end else if (timeout) begin
            nxt = RUN;
        end

        press_ok = inc_p && !mode_p && (state != RUN);
        rep_fire = armed && inc_lvl && !mode_p && !timeout &&
                   (state != RUN) &&
                   (rcnt == RCW'(REPEAT_START - 1));
        fire     = press_ok || rep_fire;

        if (mode_p || timeout || !inc_lvl || state == RUN) begin
            armed_n = 1'b0;
            rcnt_n  = '0;
        end else if (press_ok) begin
            armed_n = 1'b1;
            rcnt_n  = '0;
        end else if (armed) begin
            if (rcnt == RCW'(REPEAT_START - 1))
                rcnt_n = RCW'(REPEAT_START - REPEAT_RATE);
            else
                rcnt_n = rcnt + 1'b1;
        end

        if (nxt != state)
            phase_n = 1'b1;
        else if (fire)
            phase_n = 1'b1;
        else if (state != RUN && Tick1Hz)
            phase_n = ~phase;
    end

    // State and registered outputs.
    always_ff @(posedge CP50) begin
        if (!nCR) begin
            state      <= RUN;
            tcnt       <= '0;
            armed      <= 1'b0;
            rcnt       <= '0;
            phase      <= 1'b0;
            IncH       <= 1'b0;
            IncM       <= 1'b0;
            IncAH      <= 1'b0;
            IncAM      <= 1'b0;
            HoldRun    <= 1'b0;
            ClrSec     <= 1'b0;
            DisplayA   <= 1'b0;
            FieldBlank <= 1'b0;
        end else begin
            state      <= nxt;
            tcnt       <= (nxt == RUN) ? '0 : tcnt_n;
            armed      <= armed_n;
            rcnt       <= rcnt_n;
            phase      <= phase_n;
            IncH       <= fire && (state == SET_H);
            IncM       <= fire && (state == SET_M);
            IncAH      <= fire && (state == SET_AH);
            IncAM      <= fire && (state == SET_AM);
            HoldRun    <= (nxt == SET_H) || (nxt == SET_M);
            ClrSec     <= (state == SET_M) && (nxt != SET_M);
            DisplayA   <= (nxt == SET_AH) || (nxt == SET_AM);
            FieldBlank <= (nxt != RUN) && !phase_n;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/repeat/timeout
// parameters; each task checks one behaviour against hand-worked cycles.
module tb_time_set_ctrl;

    logic       CP50 = 1'b0;
    logic       nCR = 1'b0;
    logic       Tick1Hz = 1'b0;
    logic       KeyMode = 1'b0;
    logic       KeyInc = 1'b0;
    logic       IncH;
    logic       IncM;
    logic       IncAH;
    logic       IncAM;
    logic       HoldRun;
    logic       ClrSec;
    logic       DisplayA;
    logic       FieldBlank;
    logic [2:0] Field;

    int errors = 0;
    int checks = 0;

    time_set_ctrl #(
        .DEB_CYCLES  (4),
        .REPEAT_START(20),
        .REPEAT_RATE (5),
        .TIMEOUT_S   (3)
    ) dut (
        .CP50      (CP50),
        .nCR       (nCR),
        .Tick1Hz   (Tick1Hz),
        .KeyMode   (KeyMode),
        .KeyInc    (KeyInc),
        .IncH      (IncH),
        .IncM      (IncM),
        .IncAH     (IncAH),
        .IncAM     (IncAM),
        .HoldRun   (HoldRun),
        .ClrSec    (ClrSec),
        .DisplayA  (DisplayA),
        .FieldBlank(FieldBlank),
        .Field     (Field)
    );

    always #5 CP50 = ~CP50;

    task automatic step(input int n);
        repeat (n) @(posedge CP50);
        #1;
    endtask

    task automatic do_reset();
        KeyMode = 1'b0;
        KeyInc  = 1'b0;
        Tick1Hz = 1'b0;
        nCR     = 1'b0;
        step(2);
        nCR = 1'b1;
        step(1);
    endtask

    task automatic press_mode();
        KeyMode = 1'b1;
        step(10);
        KeyMode = 1'b0;
        step(10);
    endtask

    task automatic pulse_tick();
        Tick1Hz = 1'b1;
        step(1);
        Tick1Hz = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] v;
        KeyMode = 1'b1;
        nCR = 1'b0;
        step(2);
        v = {IncH, IncM, IncAH, IncAM, HoldRun, ClrSec,
             DisplayA, FieldBlank, Field};
        checks++;
        if (v !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", v);
        end
        nCR = 1'b1;
        step(6);
        checks++;
        if (Field !== 3'd0) begin
            errors++;
            $display("FAIL reset_field_c6 got=%0d exp=0", Field);
        end
        step(1);
        checks++;
        if (Field !== 3'd1) begin
            errors++;
            $display("FAIL reset_field_c7 got=%0d exp=1", Field);
        end
        checks++;
        if (HoldRun !== 1'b1) begin
            errors++;
            $display("FAIL reset_holdrun got=%b exp=1", HoldRun);
        end
        KeyMode = 1'b0;
        step(12);
    endtask

    task automatic test_glitch();
        KeyMode = 1'b1;
        step(3);
        KeyMode = 1'b0;
        step(12);
        checks++;
        if (Field !== 3'd1) begin
            errors++;
            $display("FAIL glitch_field got=%0d exp=1", Field);
        end
    endtask

    task automatic test_mode_steps();
        logic [2:0] exp_f [5];
        int clr = 0;
        exp_f[0] = 3'd1;
        exp_f[1] = 3'd2;
        exp_f[2] = 3'd3;
        exp_f[3] = 3'd4;
        exp_f[4] = 3'd0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 20; c++) begin
                KeyMode = (c < 10);
                step(1);
                if (ClrSec) begin
                    clr++;
                    checks++;
                    if (Field !== 3'd3) begin
                        errors++;
                        $display("FAIL clrsec_field got=%0d exp=3", Field);
                    end
                end
            end
            checks++;
            if (Field !== exp_f[p]) begin
                errors++;
                $display("FAIL mode_step%0d got=%0d exp=%0d",
                         p, Field, exp_f[p]);
            end
            checks++;
            if (HoldRun !== (exp_f[p] == 3'd1 || exp_f[p] == 3'd2)) begin
                errors++;
                $display("FAIL holdrun_step%0d got=%b", p, HoldRun);
            end
            checks++;
            if (DisplayA !== (exp_f[p] == 3'd3 || exp_f[p] == 3'd4)) begin
                errors++;
                $display("FAIL displaya_step%0d got=%b", p, DisplayA);
            end
        end
        KeyMode = 1'b0;
        checks++;
        if (clr != 1) begin
            errors++;
            $display("FAIL clrsec_count got=%0d exp=1", clr);
        end
    endtask

    task automatic test_repeat();
        logic [3:0] v;
        logic [3:0] e;
        int r;
        do_reset();
        press_mode();
        press_mode();
        checks++;
        if (Field !== 3'd2) begin
            errors++;
            $display("FAIL repeat_setup got=%0d exp=2", Field);
        end
        KeyInc = 1'b1;
        for (int c = 1; c <= 51; c++) begin
            step(1);
            r = c - 7;
            e = 4'b0000;
            if (r == 0 || r == 20 || r == 25 || r == 30 ||
                r == 35 || r == 40)
                e = 4'b0100;
            v = {IncH, IncM, IncAH, IncAM};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL repeat_c%0d got=%b exp=%b", r, v, e);
            end
            if (r == 40) KeyInc = 1'b0;
        end
        KeyInc = 1'b0;
        step(12);
    endtask

    task automatic test_timeout();
        do_reset();
        press_mode();
        press_mode();
        press_mode();
        checks++;
        if (Field !== 3'd3 || DisplayA !== 1'b1) begin
            errors++;
            $display("FAIL timeout_setup field=%0d dispa=%b exp 3/1",
                     Field, DisplayA);
        end
        pulse_tick();
        step(3);
        pulse_tick();
        step(3);
        checks++;
        if (Field !== 3'd3) begin
            errors++;
            $display("FAIL timeout_early got=%0d exp=3", Field);
        end
        pulse_tick();
        checks++;
        if (Field !== 3'd0 || DisplayA !== 1'b0) begin
            errors++;
            $display("FAIL timeout_exit field=%0d dispa=%b exp 0/0",
                     Field, DisplayA);
        end
        checks++;
        if (FieldBlank !== 1'b0) begin
            errors++;
            $display("FAIL timeout_blank got=%b exp=0", FieldBlank);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        do_reset();
        press_mode();
        KeyMode = 1'b1;
        KeyInc  = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            step(1);
            if (c == 10) KeyMode = 1'b0;
            if (IncH | IncM | IncAH | IncAM) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL simul_strobes got=%0d exp=0", n);
        end
        checks++;
        if (Field !== 3'd2) begin
            errors++;
            $display("FAIL simul_field got=%0d exp=2", Field);
        end
        KeyInc = 1'b0;
        step(12);
    endtask

    task automatic test_blink();
        int n = 0;
        do_reset();
        press_mode();
        checks++;
        if (FieldBlank !== 1'b0) begin
            errors++;
            $display("FAIL blink_entry got=%b exp=0", FieldBlank);
        end
        pulse_tick();
        checks++;
        if (FieldBlank !== 1'b1) begin
            errors++;
            $display("FAIL blink_tick1 got=%b exp=1", FieldBlank);
        end
        KeyInc = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (c == 8) KeyInc = 1'b0;
            if (IncH) n++;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL blink_inch_count got=%0d exp=1", n);
        end
        checks++;
        if (FieldBlank !== 1'b0) begin
            errors++;
            $display("FAIL blink_after_inc got=%b exp=0", FieldBlank);
        end
        pulse_tick();
        checks++;
        if (FieldBlank !== 1'b1) begin
            errors++;
            $display("FAIL blink_tick2 got=%b exp=1", FieldBlank);
        end
        pulse_tick();
        checks++;
        if (FieldBlank !== 1'b0 || Field !== 3'd1) begin
            errors++;
            $display("FAIL blink_tick3 blank=%b field=%0d exp 0/1",
                     FieldBlank, Field);
        end
    endtask

    task automatic test_run_inc();
        int n = 0;
        do_reset();
        KeyInc = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            step(1);
            if (IncH | IncM | IncAH | IncAM) n++;
        end
        KeyInc = 1'b0;
        checks++;
        if (n != 0 || Field !== 3'd0) begin
            errors++;
            $display("FAIL run_inc strobes=%0d field=%0d exp 0/0",
                     n, Field);
        end
        step(12);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_mode_steps();
        test_repeat();
        test_timeout();
        test_simultaneous();
        test_blink();
        test_run_inc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
